id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage 32-bit datapath.
- Sits directly upstream of the 32x32 register file: drives its two read addresses and captures its two read data words.
- Applies same-cycle write-back bypass, sign-extends the immediate, and detects load-use hazards.
- Holds the decoded operands in an ID/EX pipeline register that uses a valid/ready handshake.

Parameters:
- LOAD_OP, 6'b100011, opcode of a load word.
- STORE_OP, 6'b101011, opcode of a store word; uses rt as a source.
- BEQ_OP, 6'b000100, opcode of branch-equal; uses rt as a source.
- RTYPE_OP, 6'b000000, R-type opcode; destination is rd and rt is a source.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Instr  in  32  fetched instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
- InstrValid  in  1  Instr is valid.
- InstrReady  out  1  stage accepts Instr this cycle.
- Ard1  out  5  register file read address 1, equal to Instr[25:21].
- Ard2  out  5  register file read address 2, equal to Instr[20:16].
- Dout1  in  32  register file read data 1.
- Dout2  in  32  register file read data 2.
- WbAwr  in  5  write-back destination address; the same value goes to the register file.
- WbDin  in  32  write-back data.
- WbWrEn  in  1  write-back enable.
- Flush  in  1  kill the instruction in ID and the ID/EX register (branch or redirect).
- ExReady  in  1  EX stage accepts ExValid data.
- ExValid  out  1  ID/EX register holds a valid instruction.
- ExOp  out  6  registered opcode.
- ExRsVal  out  32  registered rs operand.
- ExRtVal  out  32  registered rt operand.
- ExImm  out  32  registered sign-extended imm.
- ExAwr  out  5  registered destination: rd for R-type, rt otherwise; 0 for STORE_OP and BEQ_OP.
- ExIsLoad  out  1  registered flag: ExOp == LOAD_OP.

Behaviour:
- Reset (asynchronous, active-high): ExValid=0; ExOp, ExRsVal, ExRtVal, ExImm, ExAwr, ExIsLoad all 0. Reset asserted mid-operation discards any held instruction.
- Ard1 and Ard2 are purely combinational from Instr, regardless of InstrValid.
- Bypass (combinational):
  - rsVal = WbDin if WbWrEn && WbAwr!=0 && WbAwr==Ard1, else Dout1. rtVal follows the same rule with Ard2 and Dout2.
  - Address 0 always yields 0, even if WbAwr==0 with WbWrEn=1.
- Rt use: usesRt = opcode is RTYPE_OP, STORE_OP or BEQ_OP.
- Hazard:
  - hazard = ExValid && ExIsLoad && ExAwr!=0 && (ExAwr==rs || (usesRt && ExAwr==rt)).
  - This guarantees exactly one bubble between a load and its dependent instruction. EX/MEM forwarding is handled downstream.
- InstrReady = !Flush && !hazard && (!ExValid || ExReady).
- Accept when InstrValid && InstrReady. The ID/EX register loads opcode, rsVal, rtVal, {{16{imm[15]}},imm], destination and load flag; ExValid becomes 1 on the next edge.
- When ExValid && ExReady and nothing is accepted, ExValid becomes 0 and data fields hold their last values.
- When ExValid && !ExReady, all ID/EX outputs hold.
- Flush has the highest priority (synchronous): ExValid becomes 0 at the next edge and InstrReady=0 that cycle. Upstream must redirect.
- Latency: 1 cycle from acceptance to ExValid. Throughput is 1 instruction per cycle with no hazard.
- An instruction with both rs and rt equal to a pending load destination still gets a single bubble.

Decomposition:
- Shared package datapath_pkg:
  - opcode constants LOAD_OP, STORE_OP, BEQ_OP, RTYPE_OP;
  - field slice positions;
  - width constants DATA_W=32, ADDR_W=5.
- One natural sub-module, id_bypass: two instances, each doing a 5-bit address compare and 32-bit select with the zero-register rule.
- The hazard logic and pipeline register live in id_stage.

Test Plan:
- Reset asserted mid-stream with ExValid=1 → ExValid=0 and all Ex outputs 0 immediately, without waiting for a clock edge.
- R-type rs=3, rt=4, rd=5; regfile returns 10 and 20; ExReady=1 → the next cycle gives ExValid=1, ExRsVal=10, ExRtVal=20, ExAwr=5.
- Same instruction with WbWrEn=1, WbAwr=3, WbDin=99 in the accept cycle → ExRsVal=99. With WbAwr=0, WbDin=99 and rs=0 → ExRsVal=0.
- Load with rt=7 in ID/EX, then R-type with rs=7 presented → InstrReady=0 that cycle, exactly one bubble (ExValid=0), then the R-type is accepted.
- ExReady=0 for 3 cycles with ExValid=1 → Ex outputs stable and InstrReady=0. ExReady=1 → the next instruction is accepted.
- Flush=1 with InstrValid=1 and ExValid=1 → InstrReady=0 and the next edge gives ExValid=0.
- addi with imm=16'hFFF0 → ExImm=32'hFFFFFFF0.

Source files
------------

// File: rtl/datapath_pkg.sv
// ============================================================================
// Module : datapath_pkg
// Brief  : Shared opcodes, field positions and widths for the 32-bit datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package datapath_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 6;
  localparam int IMM_W  = 16;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [OP_W-1:0] LOAD_OP  = 6'b100011;
  localparam logic [OP_W-1:0] STORE_OP = 6'b101011;
  localparam logic [OP_W-1:0] BEQ_OP   = 6'b000100;
  localparam logic [OP_W-1:0] RTYPE_OP = 6'b000000;

  function automatic logic uses_rt(input logic [OP_W-1:0] op);
    return (op == RTYPE_OP) || (op == STORE_OP) || (op == BEQ_OP);
  endfunction

  // Stores and branches write nothing, so they report r0 as destination.
  function automatic logic [ADDR_W-1:0] dest_of(input logic [OP_W-1:0]   op,
                                                input logic [ADDR_W-1:0] rt,
                                                input logic [ADDR_W-1:0] rd);
    if (op == RTYPE_OP)
      return rd;
    else if ((op == STORE_OP) || (op == BEQ_OP))
      return '0;
    else
      return rt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_bypass.sv
// ============================================================================
// Module : id_bypass
// Brief  : One register-read port with write-back bypass and hard-wired r0.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_bypass
  import datapath_pkg::*;
(
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic [ADDR_W-1:0] wb_awr_i,
  input  logic [DATA_W-1:0] wb_din_i,
  input  logic              wb_wr_en_i,
  output logic [DATA_W-1:0] val_o
);

  always_comb begin
    val_o = rf_data_i;
    if (rd_addr_i == '0)
      val_o = '0;
    else if (wb_wr_en_i && (wb_awr_i == rd_addr_i))
      val_o = wb_din_i;
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module : id_stage
// Brief  : Decode stage: regfile read, WB bypass, load-use stall, ID/EX reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_stage
  import datapath_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic              InstrValid,
  output logic              InstrReady,
  output logic [4:0]        Ard1,
  output logic [4:0]        Ard2,
  input  logic [31:0]       Dout1,
  input  logic [31:0]       Dout2,
  input  logic [4:0]        WbAwr,
  input  logic [31:0]       WbDin,
  input  logic              WbWrEn,
  input  logic              Flush,
  input  logic              ExReady,
  output logic              ExValid,
  output logic [5:0]        ExOp,
  output logic [31:0]       ExRsVal,
  output logic [31:0]       ExRtVal,
  output logic [31:0]       ExImm,
  output logic [4:0]        ExAwr,
  output logic              ExIsLoad
);

  logic [OP_W-1:0]   w_opcode;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rd;
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_hazard;
  logic              w_accept;

  logic              valid_q,   valid_d;
  logic [OP_W-1:0]   op_q,      op_d;
  logic [DATA_W-1:0] rs_val_q,  rs_val_d;
  logic [DATA_W-1:0] rt_val_q,  rt_val_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [ADDR_W-1:0] awr_q,     awr_d;
  logic              is_load_q, is_load_d;

  assign w_opcode = Instr[OPC_HI:OPC_LO];
  assign w_rs     = Instr[RS_HI:RS_LO];
  assign w_rt     = Instr[RT_HI:RT_LO];
  assign w_rd     = Instr[RD_HI:RD_LO];
  assign w_imm    = Instr[IMM_HI:IMM_LO];

  assign Ard1 = w_rs;
  assign Ard2 = w_rt;

  id_bypass u_bypass_rs (
    .rd_addr_i  (w_rs),
    .rf_data_i  (Dout1),
    .wb_awr_i   (WbAwr),
    .wb_din_i   (WbDin),
    .wb_wr_en_i (WbWrEn),
    .val_o      (w_rs_val)
  );

  id_bypass u_bypass_rt (
    .rd_addr_i  (w_rt),
    .rf_data_i  (Dout2),
    .wb_awr_i   (WbAwr),
    .wb_din_i   (WbDin),
    .wb_wr_en_i (WbWrEn),
    .val_o      (w_rt_val)
  );

  // A load in EX cannot forward yet, so a dependent consumer waits one cycle.
  assign w_hazard = valid_q && is_load_q && (awr_q != '0) &&
                    ((awr_q == w_rs) || (uses_rt(w_opcode) && (awr_q == w_rt)));

  assign InstrReady = !Flush && !w_hazard && (!valid_q || ExReady);
  assign w_accept   = InstrValid && InstrReady;

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    imm_d     = imm_q;
    awr_d     = awr_q;
    is_load_d = is_load_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d   = 1'b1;
      op_d      = w_opcode;
      rs_val_d  = w_rs_val;
      rt_val_d  = w_rt_val;
      imm_d     = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
      awr_d     = dest_of(w_opcode, w_rt, w_rd);
      is_load_d = (w_opcode == LOAD_OP);
    end else if (valid_q && ExReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      imm_q     <= '0;
      awr_q     <= '0;
      is_load_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      imm_q     <= imm_d;
      awr_q     <= awr_d;
      is_load_q <= is_load_d;
    end
  end

  assign ExValid  = valid_q;
  assign ExOp     = op_q;
  assign ExRsVal  = rs_val_q;
  assign ExRtVal  = rt_val_q;
  assign ExImm    = imm_q;
  assign ExAwr    = awr_q;
  assign ExIsLoad = is_load_q;

endmodule

`default_nettype wire
